// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-enable pipelined memory.
//   mem_state_t    : sequencer state (clear sweep, then ready for requests)
//   RD_LATENCY_MAX : largest supported read latency
//   strb_merge     : byte-wise merge of new data into an old word
package memory_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_READY
    } mem_state_t;

    localparam int unsigned RD_LATENCY_MAX = 4;
    localparam int unsigned MERGE_WIDTH    = 128;
    localparam int unsigned MERGE_STRB     = MERGE_WIDTH / 8;

    // Operates on the widest legal word. Callers zero-extend their operands
    // and keep the low DATA_WIDTH bits of the result.
    function automatic logic [MERGE_WIDTH-1:0] strb_merge(
        input logic [MERGE_WIDTH-1:0] old_word,
        input logic [MERGE_WIDTH-1:0] new_word,
        input logic [MERGE_STRB-1:0]  strb
    );
        logic [MERGE_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(MERGE_STRB); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/memory_rd_pipe.sv
// Read response pipeline: RD_LATENCY-deep valid/data shift register.
//   clk, reset       : clock, synchronous active-high reset (drops all entries)
//   in_valid_i/data_i: read accepted this edge and the word read from the array
//   out_valid_o/data_o: response; out_data_o holds the last response when idle
module memory_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

    // Data stages only load behind a valid entry, so the last stage keeps the
    // most recent response through bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[RD_LATENCY-1];
    assign out_data_o  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/memory_be_pipe.sv
// Word memory with per-byte write strobes, valid/ready request port and a
// pipelined read response. After every reset the array is swept to zero, one
// word per cycle, before requests are accepted.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready low while clearing)
//   req_we, req_addr    : 1 = write, 0 = read; word address
//   req_wstrb, req_wdata: byte enables and data for writes
//   rsp_valid, rsp_rdata: read response, RD_LATENCY cycles after acceptance
//   init_busy           : array clear in progress
module memory_be_pipe
    import memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, busy_q;
    logic                  clear_en;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                   accept, wr_en, rd_en;
    logic [MERGE_WIDTH-1:0] old_ext, new_ext, merged_ext;
    logic [MERGE_STRB-1:0]  strb_ext;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic                   unused_merge;

    // Sequencer: sweep every address once, then stay ready until reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_en = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clear_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: ;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // ready/busy are flopped from state_d so they flip on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_READY);
            busy_q  <= (state_d == ST_CLEAR);
        end
    end

    assign req_ready = ready_q;
    assign init_busy = busy_q;

    assign accept = req_valid & ready_q;
    assign wr_en  = accept & req_we;
    assign rd_en  = accept & ~req_we;

    always_comb begin
        old_ext                    = '0;
        new_ext                    = '0;
        strb_ext                   = '0;
        old_ext[DATA_WIDTH-1:0]    = mem_q[req_addr];
        new_ext[DATA_WIDTH-1:0]    = req_wdata;
        strb_ext[STRB_WIDTH-1:0]   = req_wstrb;
        merged_ext                 = strb_merge(old_ext, new_ext, strb_ext);
        wr_word                    = merged_ext[DATA_WIDTH-1:0];
    end

    // Upper merge bits are always zero for narrow words.
    assign unused_merge = ^merged_ext;

    // Array is left untouched while reset is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clear_en) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                mem_q[req_addr] <= wr_word;
            end
        end
    end

    memory_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (rd_en),
        .in_data_i   (mem_q[req_addr]),
        .out_valid_o (rsp_valid),
        .out_data_o  (rsp_rdata)
    );

endmodule
